coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Payment front-end directly upstream of the coffee vending controller.
- Accepts coins of four denominations, accumulates credit and checks it against a programmable price.
- Issues a one-cycle paid pulse (coin_avail) to the vending controller only when that controller is idle.
- Returns change, or the full credit on cancel or timeout, as a paced train of 10-unit coin pulses.

Parameters:
- PRICE, 50, drink price in currency units; must be a multiple of 10 and ≤ MAX_CREDIT.
- MAX_CREDIT, 200, maximum credit held; a coin that would exceed it is rejected.
- CREDIT_W, 8, width of the credit register; must hold MAX_CREDIT.
- TIMEOUT_CYCLES, 30000000, inactivity limit before automatic refund (300 ms at 100 MHz).
- PULSE_GAP, 4, low cycles between consecutive change_pulse highs.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- coin_in  input  1  one-cycle strobe: a coin is present
- coin_value  input  2  denomination, valid with coin_in: 00=10, 01=20, 10=50, 11=100
- cancel  input  1  one-cycle customer cancel request
- machine_idle  input  1  high while the downstream vending controller is in IDLE
- coin_avail  output  1  one-cycle "paid" pulse to the vending controller
- coin_reject  output  1  one-cycle pulse: the offered coin is not accepted
- change_pulse  output  1  one-cycle pulse: eject one 10-unit coin
- credit  output  CREDIT_W  current credit, for display
- busy  output  1  high in the REQUEST and CHANGE states

Behaviour:
- Reset is sampled on the rising edge of clk only; reset_n is asserted when low.
- Reset values: state IDLE, credit 0, timer 0; coin_avail, coin_reject, change_pulse and busy all 0.
- Reset asserted mid-operation: current credit is discarded and no further change pulses are issued.
- All outputs are registered.
- State encoding: IDLE=0, COLLECT=1, REQUEST=2, CHANGE=3.
- Coin acceptance:
  - Coins are accepted only in IDLE or COLLECT.
  - A coin is accepted only if credit + value ≤ MAX_CREDIT; the sum is computed at CREDIT_W+1 bits, so there is no wrap-around.
  - On acceptance, credit is updated on the next edge.
  - On rejection (wrong state or over limit), coin_reject is high on the next cycle and credit is unchanged.
- Inactivity timer: reset to 0 on every accepted coin, and on every entry to COLLECT.
- IDLE:
  - Accepted coin → COLLECT.
  - cancel is ignored (no credit is held).
- COLLECT, with priority in this order:
  1. cancel: any coin on the same cycle is rejected; → CHANGE, refunding the full credit.
  2. credit ≥ PRICE and machine_idle=1 → REQUEST; credit -= PRICE on the same edge.
  3. credit < PRICE and timer == TIMEOUT_CYCLES-1 → CHANGE, refunding the full credit.
  4. Otherwise stay; timer increments only while credit < PRICE.
- Surplus credit while waiting:
  - With credit ≥ PRICE and machine_idle=0, the block holds in COLLECT with no timeout.
  - Further coins are still accepted up to MAX_CREDIT.
- REQUEST:
  - coin_avail = 1 for exactly this one cycle.
  - Next state: CHANGE if credit > 0, else IDLE.
  - A coin arriving on this cycle is rejected.
- CHANGE:
  - Emits change_pulse high for 1 cycle, then low for PULSE_GAP cycles; repeats.
  - credit -= 10 on each pulse.
  - After the pulse that brings credit to 0, the gap completes, then → IDLE.
  - Coins are rejected and cancel is ignored.
- Latency:
  - Accepting coin at cycle N with credit reaching PRICE and machine_idle=1: credit valid at N+1, coin_avail high at N+2.
  - The first change_pulse is on the cycle after REQUEST, or on the cycle after a cancel/timeout decision.
- Invariants:
  - Only one coin_avail per PRICE deducted.
  - coin_avail is never asserted while machine_idle=0 was sampled on the decision cycle.
  - Total change pulses × 10 = credit refunded.

Test Plan:
- Exact payment, machine_idle=1: one 50 coin → credit=50 at N+1, coin_avail pulse at N+2, no change_pulse, back in IDLE at N+3, credit=0.
- Overpayment: coins 20, 20, 20 → coin_avail once, credit 60→10, exactly one change_pulse, then IDLE.
- Cancel: coins 10 and 20, then cancel → 3 change_pulses spaced PULSE_GAP+1 cycles apart, no coin_avail; a coin on the cancel cycle gets coin_reject.
- Timeout with TIMEOUT_CYCLES=100: one 20 coin, no further activity → CHANGE entered 100 cycles later, 2 change_pulses.
- Busy downstream: machine_idle=0, coins 100 and 100 (credit=200), then a 10 coin → coin_reject; raise machine_idle → coin_avail, then 15 change_pulses.
- Reset mid-CHANGE: reset_n low for 1 cycle after the 2nd pulse → all outputs 0, credit 0, no further pulses.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin credit accumulator: accepts coins, asks the vending controller to dispense once PRICE is met, refunds change as paced 10-unit pulses.
// Latency: credit updates one edge after a coin; coin_avail follows one cycle later when the controller is idle; coins are rejected outside IDLE/COLLECT.
module coin_acceptor #(
    parameter int PRICE          = 50,
    parameter int MAX_CREDIT     = 200,
    parameter int CREDIT_W       = 8,
    parameter int TIMEOUT_CYCLES = 30000000,
    parameter int PULSE_GAP      = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_in,
    input  logic [1:0]          coin_value,
    input  logic                cancel,
    input  logic                machine_idle,
    output logic                coin_avail,
    output logic                coin_reject,
    output logic                change_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W   = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C      = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] STEP_C     = CREDIT_W'(10);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(PULSE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REQUEST = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [CREDIT_W-1:0]  credit_n, credit_in;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [GAP_W-1:0]     gap_cnt, gap_n;
    logic [CREDIT_W:0]    coin_amt, coin_sum;
    logic                 coin_ok;
    logic                 avail_n, reject_n, pulse_n, busy_n;

    always_comb begin
        coin_amt = '0;
        case (coin_value)
            2'b00:   coin_amt = (CREDIT_W+1)'(10);
            2'b01:   coin_amt = (CREDIT_W+1)'(20);
            2'b10:   coin_amt = (CREDIT_W+1)'(50);
            default: coin_amt = (CREDIT_W+1)'(100);
        endcase
        // one extra bit so an over-limit sum cannot wrap into an acceptable value
        coin_sum  = {1'b0, credit} + coin_amt;
        coin_ok   = coin_in && (coin_sum <= MAX_C) &&
                    ((state == IDLE) || ((state == COLLECT) && !cancel));
        credit_in = coin_ok ? coin_sum[CREDIT_W-1:0] : credit;

        state_n  = state;
        credit_n = credit;
        timer_n  = timer;
        gap_n    = gap_cnt;
        pulse_n  = 1'b0;
        reject_n = coin_in && !coin_ok;

        case (state)
            IDLE: begin
                if (coin_ok) begin
                    state_n  = COLLECT;
                    credit_n = credit_in;
                    timer_n  = '0;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    state_n = CHANGE;
                    pulse_n = 1'b1;
                end else if ((credit >= PRICE_C) && machine_idle) begin
                    state_n  = REQUEST;
                    credit_n = credit_in - PRICE_C;
                end else if ((credit < PRICE_C) && (timer == TIMER_LAST) && !coin_ok) begin
                    state_n = CHANGE;
                    pulse_n = 1'b1;
                end else begin
                    credit_n = credit_in;
                    if (coin_ok)
                        timer_n = '0;
                    else if (credit < PRICE_C)
                        timer_n = timer + TIMER_W'(1);
                end
            end
            REQUEST: begin
                if (credit != '0) begin
                    state_n = CHANGE;
                    pulse_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            CHANGE: begin
                // credit drops at the end of each pulse cycle; the gap then runs out before the next pulse or exit
                if (change_pulse) begin
                    credit_n = credit - STEP_C;
                    gap_n    = '0;
                end else if (gap_cnt == GAP_LAST) begin
                    if (credit == '0)
                        state_n = IDLE;
                    else
                        pulse_n = 1'b1;
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        avail_n = (state_n == REQUEST);
        busy_n  = (state_n == REQUEST) || (state_n == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            credit       <= '0;
            timer        <= '0;
            gap_cnt      <= '0;
            coin_avail   <= 1'b0;
            coin_reject  <= 1'b0;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            timer        <= timer_n;
            gap_cnt      <= gap_n;
            coin_avail   <= avail_n;
            coin_reject  <= reject_n;
            change_pulse <= pulse_n;
            busy         <= busy_n;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (TIMEOUT_CYCLES shortened to 100).
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       coin_in;
    logic [1:0] coin_value;
    logic       cancel;
    logic       machine_idle;
    logic       coin_avail;
    logic       coin_reject;
    logic       change_pulse;
    logic [7:0] credit;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_pulse = 0;
    int n_avail = 0;
    int avail_credit = -1;
    int pulse_at[$];

    coin_acceptor #(
        .PRICE(50), .MAX_CREDIT(200), .CREDIT_W(8), .TIMEOUT_CYCLES(100), .PULSE_GAP(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .coin_in(coin_in), .coin_value(coin_value),
        .cancel(cancel), .machine_idle(machine_idle), .coin_avail(coin_avail),
        .coin_reject(coin_reject), .change_pulse(change_pulse), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (change_pulse) begin
            n_pulse++;
            pulse_at.push_back(cyc);
        end
        if (coin_avail) begin
            n_avail++;
            avail_credit = int'(credit);
        end
    endtask

    task automatic clear_counts();
        n_pulse = 0;
        n_avail = 0;
        avail_credit = -1;
        pulse_at.delete();
    endtask

    task automatic put_coin(input logic [1:0] v);
        coin_in = 1'b1;
        coin_value = v;
        tick();
        coin_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if ({coin_avail, coin_reject, change_pulse, busy} !== 4'b0000) begin errors++; $display("FAIL reset_outputs: got %b want 0000", {coin_avail, coin_reject, change_pulse, busy}); end
        checks++; if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit: got %0d want 0", credit); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_exact_payment();
        clear_counts();
        machine_idle = 1'b1;
        put_coin(2'b10);
        checks++; if (credit !== 8'd50 || coin_avail !== 1'b0) begin errors++; $display("FAIL exact_n1: credit=%0d avail=%b want 50/0", credit, coin_avail); end
        tick();
        checks++; if (coin_avail !== 1'b1 || busy !== 1'b1 || credit !== 8'd0) begin errors++; $display("FAIL exact_n2: avail=%b busy=%b credit=%0d want 1/1/0", coin_avail, busy, credit); end
        tick();
        checks++; if (coin_avail !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL exact_n3: avail=%b busy=%b want 0/0", coin_avail, busy); end
        repeat (10) tick();
        checks++; if (n_pulse !== 0 || n_avail !== 1) begin errors++; $display("FAIL exact_counts: pulses=%0d avail=%0d want 0/1", n_pulse, n_avail); end
    endtask

    task automatic test_overpay();
        clear_counts();
        put_coin(2'b01);
        put_coin(2'b01);
        put_coin(2'b01);
        repeat (30) tick();
        checks++; if (n_avail !== 1 || avail_credit !== 10) begin errors++; $display("FAIL overpay_avail: count=%0d credit_at_avail=%0d want 1/10", n_avail, avail_credit); end
        checks++; if (n_pulse !== 1) begin errors++; $display("FAIL overpay_pulses: got %0d want 1", n_pulse); end
        checks++; if (credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL overpay_end: credit=%0d busy=%b want 0/0", credit, busy); end
    endtask

    task automatic test_cancel();
        clear_counts();
        put_coin(2'b00);
        put_coin(2'b01);
        cancel = 1'b1;
        coin_in = 1'b1;
        coin_value = 2'b00;
        tick();
        cancel = 1'b0;
        coin_in = 1'b0;
        checks++; if (coin_reject !== 1'b1 || change_pulse !== 1'b1 || credit !== 8'd30) begin errors++; $display("FAIL cancel_first: reject=%b pulse=%b credit=%0d want 1/1/30", coin_reject, change_pulse, credit); end
        repeat (25) tick();
        checks++; if (pulse_at.size() != 3 || pulse_at[1] - pulse_at[0] != 5 || pulse_at[2] - pulse_at[1] != 5) begin errors++; $display("FAIL cancel_pulses: count=%0d want 3 spaced 5", pulse_at.size()); end
        checks++; if (n_avail !== 0 || credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL cancel_end: avail=%0d credit=%0d busy=%b want 0/0/0", n_avail, credit, busy); end
    endtask

    task automatic test_timeout();
        int t0;
        int first;
        clear_counts();
        put_coin(2'b01);
        t0 = cyc;
        repeat (130) tick();
        first = (pulse_at.size() > 0) ? pulse_at[0] - t0 : -1;
        checks++; if (first != 100) begin errors++; $display("FAIL timeout_first_pulse: got offset %0d want 100", first); end
        checks++; if (n_pulse !== 2 || n_avail !== 0) begin errors++; $display("FAIL timeout_counts: pulses=%0d avail=%0d want 2/0", n_pulse, n_avail); end
        checks++; if (credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_end: credit=%0d busy=%b want 0/0", credit, busy); end
    endtask

    task automatic test_busy_downstream();
        clear_counts();
        machine_idle = 1'b0;
        put_coin(2'b11);
        put_coin(2'b11);
        checks++; if (credit !== 8'd200 || coin_reject !== 1'b0) begin errors++; $display("FAIL busy_fill: credit=%0d reject=%b want 200/0", credit, coin_reject); end
        put_coin(2'b00);
        checks++; if (coin_reject !== 1'b1 || credit !== 8'd200) begin errors++; $display("FAIL busy_over_limit: reject=%b credit=%0d want 1/200", coin_reject, credit); end
        repeat (10) tick();
        checks++; if (n_avail !== 0 || n_pulse !== 0 || credit !== 8'd200) begin errors++; $display("FAIL busy_hold: avail=%0d pulses=%0d credit=%0d want 0/0/200", n_avail, n_pulse, credit); end
        machine_idle = 1'b1;
        for (int i = 0; i < 10 && n_pulse == 0; i++) tick();
        put_coin(2'b10);
        checks++; if (coin_reject !== 1'b1 || credit !== 8'd140) begin errors++; $display("FAIL busy_coin_in_change: reject=%b credit=%0d want 1/140", coin_reject, credit); end
        repeat (100) tick();
        checks++; if (n_avail !== 1 || avail_credit !== 150) begin errors++; $display("FAIL busy_avail: count=%0d credit_at_avail=%0d want 1/150", n_avail, avail_credit); end
        checks++; if (n_pulse !== 15 || credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL busy_change: pulses=%0d credit=%0d busy=%b want 15/0/0", n_pulse, credit, busy); end
    endtask

    task automatic test_reset_mid_change();
        clear_counts();
        machine_idle = 1'b0;
        put_coin(2'b10);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        for (int i = 0; i < 30 && n_pulse < 2; i++) tick();
        checks++; if (n_pulse !== 2 || credit !== 8'd40) begin errors++; $display("FAIL midreset_pre: pulses=%0d credit=%0d want 2/40", n_pulse, credit); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++; if ({coin_avail, coin_reject, change_pulse, busy} !== 4'b0000 || credit !== 8'd0) begin errors++; $display("FAIL midreset_outputs: flags=%b credit=%0d want 0000/0", {coin_avail, coin_reject, change_pulse, busy}, credit); end
        repeat (30) tick();
        checks++; if (n_pulse !== 2 || credit !== 8'd0) begin errors++; $display("FAIL midreset_after: pulses=%0d credit=%0d want 2/0", n_pulse, credit); end
        machine_idle = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        coin_in = 1'b0;
        coin_value = 2'b00;
        cancel = 1'b0;
        machine_idle = 1'b1;
        test_reset();
        test_exact_payment();
        test_overpay();
        test_cancel();
        test_timeout();
        test_busy_downstream();
        test_reset_mid_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
